// File: rtl/uart_rx_mmio_pkg.sv
// Shared types and register-map constants for the UART receive peripheral.
package uart_rx_mmio_pkg;

  // Receive frame state machine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Register offsets as seen in address[3:2].
  localparam logic [1:0] RX_DATA_OFS = 2'd0;
  localparam logic [1:0] RX_STAT_OFS = 2'd1;

  // STATUS register bit positions.
  localparam int unsigned STAT_NEMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT   = 1;
  localparam int unsigned STAT_FERR_BIT   = 2;
  localparam int unsigned STAT_OVR_BIT    = 3;

endpackage

// File: rtl/uart_rx_mmio_if.sv
// MEM-stage read port of the UART receive peripheral.
interface uart_rx_mmio_if;
  logic [31:0] address;
  logic        rd_en;
  logic [31:0] data_out;
  logic        rx_irq;

  modport master (output address, output rd_en, input data_out, input rx_irq);
  modport slave  (input address, input rd_en, output data_out, output rx_irq);
endinterface

// File: rtl/uart_rx_mmio_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and extra-MSB pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Pop only when data exists; a push into a full FIFO is allowed only if a pop frees the slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_rx_mmio.sv
// UART 8N1 receiver with receive FIFO, exposed as RXDATA/STATUS memory-mapped registers.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           UART_Rx,
  uart_rx_mmio_if.slave  bus
);
  localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_s;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             push_c;
  logic             ferr_set_c;
  logic             overrun;
  logic             frame_err;
  logic [1:0]       reg_ofs;
  logic             pop_c;
  logic             stat_rd_c;
  logic             ovr_set_c;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_addr;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_Rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame state, bit timing and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  // Next-state logic: half-bit start qualification, then full-bit spaced samples.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    push_c      = 1'b0;
    ferr_set_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt    = '0;
          push_c     = rx_s;
          ferr_set_c = !rx_s;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign reg_ofs     = bus.address[3:2];
  assign unused_addr = ^{bus.address[31:4], bus.address[1:0]};
  assign pop_c       = bus.rd_en && (reg_ofs == RX_DATA_OFS) && !fifo_empty;
  assign stat_rd_c   = bus.rd_en && (reg_ofs == RX_STAT_OFS);
  assign ovr_set_c   = push_c && fifo_full && !pop_c;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (shift),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky error flags; a new error in the same cycle as a STATUS read keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set_c  || (overrun   && !stat_rd_c);
      frame_err <= ferr_set_c || (frame_err && !stat_rd_c);
    end
  end

  // Same-cycle read mux for the MEM stage.
  always_comb begin
    bus.data_out = '0;
    case (reg_ofs)
      RX_DATA_OFS: begin
        if (!fifo_empty) bus.data_out = {24'b0, fifo_dout};
      end
      RX_STAT_OFS: begin
        bus.data_out[STAT_NEMPTY_BIT] = !fifo_empty;
        bus.data_out[STAT_FULL_BIT]   = fifo_full;
        bus.data_out[STAT_FERR_BIT]   = frame_err;
        bus.data_out[STAT_OVR_BIT]    = overrun;
      end
      default: ;
    endcase
  end

  assign bus.rx_irq = !fifo_empty;
endmodule
